// File: rtl/tlk2711_rx_deframer.sv
// Receive-side deframer for the TLK2711 link: acquires lock from idle characters,
// strips SOF/EOF, checks the additive checksum and emits payload as a valid/last stream.
module tlk2711_rx_deframer #(
    parameter int MAX_WORDS  = 1024,
    parameter int LOCK_IDLES = 16
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic [15:0] i_rxd,
    input  logic        i_rkmsb,
    input  logic        i_rklsb,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_last,
    output logic        o_frame_ok,
    output logic        o_err,
    output logic        o_link_up,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt
);

    localparam int RCNT_W = $clog2(MAX_WORDS + 3);
    localparam int ICNT_W = $clog2(LOCK_IDLES + 1);
    localparam logic [RCNT_W-1:0] RCNT_ZERO  = {RCNT_W{1'b0}};
    localparam logic [RCNT_W-1:0] RCNT_ONE   = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_TWO   = RCNT_W'(2);
    localparam logic [RCNT_W-1:0] RCNT_LIMIT = RCNT_W'(MAX_WORDS + 1);
    localparam logic [ICNT_W-1:0] ICNT_ZERO  = {ICNT_W{1'b0}};
    localparam logic [ICNT_W-1:0] ICNT_ONE   = ICNT_W'(1);
    localparam logic [ICNT_W-1:0] ICNT_LOCK  = ICNT_W'(LOCK_IDLES);

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_IDLE = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_SOF     = 3'd1,
        W_EOF     = 3'd2,
        W_DATA    = 3'd3,
        W_CODEERR = 3'd4
    } wclass_t;

    function automatic wclass_t classify(input logic [15:0] w, input logic km, input logic kl);
        wclass_t c;
        if (!km && !kl) begin
            c = W_DATA;
        end else if (!km && kl && (w == 16'hC5BC)) begin
            c = W_IDLE;
        end else if (km && kl && (w == 16'hFBFB)) begin
            c = W_SOF;
        end else if (km && kl && (w == 16'hFDFD)) begin
            c = W_EOF;
        end else begin
            c = W_CODEERR;
        end
        return c;
    endfunction

    logic [15:0]       rxd_q;
    logic              rkmsb_q, rklsb_q;
    wclass_t           wclass;
    state_t            state_q, state_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [15:0]       sum_q, sum_d;
    logic [15:0]       h0_q, h0_d, h1_q, h1_d;
    logic              h0_vld_q, h0_vld_d, h1_vld_q, h1_vld_d;
    logic              link_q, link_d;
    logic [15:0]       data_q, data_d;
    logic              valid_q, valid_d, last_q, last_d, ok_q, ok_d, err_q, err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

    assign wclass = classify(rxd_q, rkmsb_q, rklsb_q);

    // Next-state, hold-stage and output decode on the registered receive word.
    always_comb begin
        state_d  = state_q;
        icnt_d   = icnt_q;
        rcnt_d   = rcnt_q;
        sum_d    = sum_q;
        h0_d     = h0_q;
        h1_d     = h1_q;
        h0_vld_d = h0_vld_q;
        h1_vld_d = h1_vld_q;
        link_d   = link_q;
        data_d   = 16'h0000;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_LOS: begin
                if (wclass == W_IDLE) begin
                    if ((icnt_q + ICNT_ONE) == ICNT_LOCK) begin
                        icnt_d  = ICNT_ZERO;
                        link_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        icnt_d = icnt_q + ICNT_ONE;
                    end
                end else begin
                    icnt_d = ICNT_ZERO;
                end
            end
            ST_IDLE: begin
                case (wclass)
                    W_SOF: begin
                        state_d  = ST_DATA;
                        sum_d    = 16'h0000;
                        rcnt_d   = RCNT_ZERO;
                        h0_vld_d = 1'b0;
                        h1_vld_d = 1'b0;
                    end
                    W_EOF: err_d = 1'b1;
                    W_CODEERR: begin
                        err_d   = 1'b1;
                        link_d  = 1'b0;
                        icnt_d  = ICNT_ZERO;
                        state_d = ST_LOS;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_DATA: begin
                case (wclass)
                    W_DATA: begin
                        // h0 is always a payload word here, so it is safe to emit even on overflow.
                        valid_d = h0_vld_q;
                        data_d  = h0_vld_q ? h0_q : 16'h0000;
                        if (rcnt_q == RCNT_LIMIT) begin
                            err_d    = 1'b1;
                            h0_vld_d = 1'b0;
                            h1_vld_d = 1'b0;
                            state_d  = ST_DROP;
                        end else begin
                            h0_d     = h1_q;
                            h0_vld_d = h1_vld_q;
                            sum_d    = h1_vld_q ? (sum_q + h1_q) : sum_q;
                            h1_d     = rxd_q;
                            h1_vld_d = 1'b1;
                            rcnt_d   = rcnt_q + RCNT_ONE;
                        end
                    end
                    W_EOF: begin
                        if (rcnt_q < RCNT_TWO) begin
                            err_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            last_d  = 1'b1;
                            ok_d    = (sum_q == h1_q);
                            data_d  = h0_q;
                        end
                        h0_vld_d = 1'b0;
                        h1_vld_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                    W_SOF: begin
                        err_d    = 1'b1;
                        sum_d    = 16'h0000;
                        rcnt_d   = RCNT_ZERO;
                        h0_vld_d = 1'b0;
                        h1_vld_d = 1'b0;
                    end
                    W_CODEERR: begin
                        err_d    = 1'b1;
                        link_d   = 1'b0;
                        icnt_d   = ICNT_ZERO;
                        h0_vld_d = 1'b0;
                        h1_vld_d = 1'b0;
                        state_d  = ST_LOS;
                    end
                    default: state_d = ST_DATA;
                endcase
            end
            ST_DROP: begin
                case (wclass)
                    W_EOF: state_d = ST_IDLE;
                    W_SOF: begin
                        state_d  = ST_DATA;
                        sum_d    = 16'h0000;
                        rcnt_d   = RCNT_ZERO;
                        h0_vld_d = 1'b0;
                        h1_vld_d = 1'b0;
                    end
                    W_CODEERR: begin
                        err_d   = 1'b1;
                        link_d  = 1'b0;
                        icnt_d  = ICNT_ZERO;
                        state_d = ST_LOS;
                    end
                    default: state_d = ST_DROP;
                endcase
            end
            default: begin
                state_d = ST_LOS;
                link_d  = 1'b0;
                icnt_d  = ICNT_ZERO;
            end
        endcase
    end

    // Saturating frame and error counters.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (valid_d && last_d && ok_d && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Input capture, state and registered outputs.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            rxd_q       <= 16'h0000;
            rkmsb_q     <= 1'b0;
            rklsb_q     <= 1'b0;
            state_q     <= ST_LOS;
            icnt_q      <= ICNT_ZERO;
            rcnt_q      <= RCNT_ZERO;
            sum_q       <= 16'h0000;
            h0_q        <= 16'h0000;
            h1_q        <= 16'h0000;
            h0_vld_q    <= 1'b0;
            h1_vld_q    <= 1'b0;
            link_q      <= 1'b0;
            data_q      <= 16'h0000;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
        end else begin
            rxd_q       <= i_rxd;
            rkmsb_q     <= i_rkmsb;
            rklsb_q     <= i_rklsb;
            state_q     <= state_d;
            icnt_q      <= icnt_d;
            rcnt_q      <= rcnt_d;
            sum_q       <= sum_d;
            h0_q        <= h0_d;
            h1_q        <= h1_d;
            h0_vld_q    <= h0_vld_d;
            h1_vld_q    <= h1_vld_d;
            link_q      <= link_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign o_frame_ok  = ok_q;
    assign o_err       = err_q;
    assign o_link_up   = link_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tlk2711_rx_deframer.sv
// Directed bench for tlk2711_rx_deframer (MAX_WORDS=4, LOCK_IDLES=16);
// a negedge monitor collects emitted beats and error pulses.
module tb_tlk2711_rx_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rxd = 16'h0000;
    logic        rkmsb = 1'b0;
    logic        rklsb = 1'b0;
    logic [15:0] o_data;
    logic        o_valid, o_last, o_frame_ok, o_err, o_link_up;
    logic [15:0] o_frame_cnt, o_err_cnt;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_before;
    logic [17:0] beats[$];

    tlk2711_rx_deframer #(.MAX_WORDS(4), .LOCK_IDLES(16)) dut (
        .rx_clk(clk), .rst(rst), .i_rxd(rxd), .i_rkmsb(rkmsb), .i_rklsb(rklsb),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_frame_ok(o_frame_ok),
        .o_err(o_err), .o_link_up(o_link_up), .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    // Beat entries are {last, frame_ok, data}.
    always @(negedge clk) begin
        if (o_valid === 1'b1) beats.push_back({o_last, o_frame_ok, o_data});
        if (o_err === 1'b1) err_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Outputs seen after a drive reflect the word driven two drives earlier.
    task automatic drive(input logic [15:0] d, input logic km, input logic kl);
        @(negedge clk);
        #1;
        rxd = d;
        rkmsb = km;
        rklsb = kl;
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) drive(16'hC5BC, 1'b0, 1'b1);
    endtask

    task automatic sof();
        drive(16'hFBFB, 1'b1, 1'b1);
    endtask

    task automatic eof();
        drive(16'hFDFD, 1'b1, 1'b1);
    endtask

    task automatic dat(input logic [15:0] d);
        drive(d, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) dat(16'h0000);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_link", {31'd0, o_link_up}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_cnts", {o_frame_cnt, o_err_cnt}, 32'd0);
        dat(16'h0000);
        rst = 1'b0;

        // Lock: 15 IDLE, 1 DATA, 16 IDLE
        idles(15);
        dat(16'h0000);
        idles(16);
        chk("lock_k", {31'd0, o_link_up}, 32'd0);
        idles(1);
        chk("lock_k1", {31'd0, o_link_up}, 32'd0);
        idles(1);
        chk("lock_k2", {31'd0, o_link_up}, 32'd1);
        chk("lock_noerr", err_seen, 32'd0);
        idles(2);
        beats.delete();

        // Good frame with exact latency on the final beat
        sof(); dat(16'h0001); dat(16'h0002); dat(16'h0003); dat(16'h0006); eof();
        idles(1);
        chk("good_beat2", {14'd0, o_valid, o_last, o_data}, {14'd0, 1'b1, 1'b0, 16'h0002});
        idles(1);
        chk("good_last", {13'd0, o_valid, o_last, o_frame_ok, o_data}, {13'd0, 3'b111, 16'h0003});
        chk("good_fcnt", o_frame_cnt, 32'd1);
        idles(1);
        chk("good_idle_valid", {31'd0, o_valid}, 32'd0);
        chk("good_nbeats", beats.size(), 32'd3);
        chk("good_b0", beats[0], {2'b00, 16'h0001});
        chk("good_b1", beats[1], {2'b00, 16'h0002});
        chk("good_b2", beats[2], {2'b11, 16'h0003});
        chk("good_noerr", err_seen, 32'd0);
        beats.delete();

        // Bad checksum
        sof(); dat(16'h0001); dat(16'h0002); dat(16'h0003); dat(16'h0007); eof();
        idles(3);
        chk("bad_nbeats", beats.size(), 32'd3);
        chk("bad_b2", beats[2], {2'b10, 16'h0003});
        chk("bad_fcnt", o_frame_cnt, 32'd1);
        chk("bad_ecnt", o_err_cnt, 32'd0);
        beats.delete();

        // Short frame
        sof(); dat(16'h1234); eof();
        idles(3);
        chk("short_nbeats", beats.size(), 32'd0);
        chk("short_err", err_seen, 32'd1);
        chk("short_ecnt", o_err_cnt, 32'd1);

        // Frame with 3 IDLE fill words mid-payload
        sof(); dat(16'h0010); idles(3); dat(16'h0020); dat(16'h0030); dat(16'h0060); eof();
        idles(3);
        chk("gap_nbeats", beats.size(), 32'd3);
        chk("gap_b0", beats[0], {2'b00, 16'h0010});
        chk("gap_b1", beats[1], {2'b00, 16'h0020});
        chk("gap_b2", beats[2], {2'b11, 16'h0030});
        chk("gap_fcnt", o_frame_cnt, 32'd2);
        chk("gap_noerr", err_seen, 32'd1);
        beats.delete();

        // Overflow: 6 payload words with MAX_WORDS=4
        sof();
        for (int i = 1; i <= 6; i++) dat(16'(i));
        dat(16'h0015); eof();
        idles(3);
        chk("ovf_nbeats", beats.size(), 32'd4);
        chk("ovf_b0", beats[0], {2'b00, 16'h0001});
        chk("ovf_b3", beats[3], {2'b00, 16'h0004});
        chk("ovf_err", err_seen, 32'd2);
        chk("ovf_ecnt", o_err_cnt, 32'd2);
        chk("ovf_fcnt", o_frame_cnt, 32'd2);
        beats.delete();

        // Exactly MAX_WORDS payload words after the drop
        sof(); dat(16'h0001); dat(16'h0002); dat(16'h0003); dat(16'h0004); dat(16'h000A); eof();
        idles(3);
        chk("max_nbeats", beats.size(), 32'd4);
        chk("max_b3", beats[3], {2'b11, 16'h0004});
        chk("max_fcnt", o_frame_cnt, 32'd3);
        chk("max_noerr", err_seen, 32'd2);
        beats.delete();

        // Code error mid-frame, then re-lock
        sof(); dat(16'h0100); dat(16'h0200);
        drive(16'hFFFF, 1'b1, 1'b1);
        idles(2);
        chk("cerr_pulse", {31'd0, o_err}, 32'd1);
        chk("cerr_link", {31'd0, o_link_up}, 32'd0);
        chk("cerr_ecnt", o_err_cnt, 32'd3);
        chk("cerr_nbeats", beats.size(), 32'd0);
        idles(16);
        chk("relock", {31'd0, o_link_up}, 32'd1);
        chk("relock_noerr", err_seen, 32'd3);
        beats.delete();

        // Reset mid-frame
        sof(); dat(16'h1111); dat(16'h2222); dat(16'h3333); dat(16'h4444);
        dat(16'h5555);
        rst = 1'b1;
        chk("prerst_beat", {15'd0, o_valid, o_data}, {15'd0, 1'b1, 16'h1111});
        err_before = err_seen;
        dat(16'h6666);
        chk("midrst_valid", {31'd0, o_valid}, 32'd0);
        chk("midrst_data", o_data, 32'd0);
        chk("midrst_flags", {28'd0, o_last, o_frame_ok, o_err, o_link_up}, 32'd0);
        chk("midrst_cnts", {o_frame_cnt, o_err_cnt}, 32'd0);
        dat(16'h0000);
        rst = 1'b0;
        idles(4);
        chk("midrst_noerr", err_seen, err_before);
        chk("midrst_link", {31'd0, o_link_up}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
